// File: rtl/multdiv_pkg.sv
// Shared types and constants for the sequential signed multiply/divide unit.
package multdiv_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] negate(input logic [DATA_WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] ? negate(x) : x;
  endfunction

endpackage

// File: rtl/addsub_32bit.sv
// 32-bit adder with carry-in; subtract inverts b and forces the carry-in high.
module addsub_32bit
  import multdiv_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  cin_i,
  input  logic                  sub_i,
  output logic [DATA_WIDTH-1:0] sum_o,
  output logic                  cout_o,
  output logic                  ovf_o
);

  logic [DATA_WIDTH-1:0] b_eff;
  logic                  carry_in;

  assign b_eff    = sub_i ? ~b_i : b_i;
  assign carry_in = sub_i | cin_i;
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, carry_in};
  assign ovf_o = (a_i[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1]) &&
                 (sum_o[DATA_WIDTH-1] != a_i[DATA_WIDTH-1]);

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequential signed multiply (radix-2 Booth) and restoring divide sharing one add/sub;
// 32 iterations plus a finalize edge, then a one-cycle ready strobe in DONE.
module multdiv_sequencer
  import multdiv_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ctrl_MULT,
  input  logic                  ctrl_DIV,
  input  logic [DATA_WIDTH-1:0] data_operandA,
  input  logic [DATA_WIDTH-1:0] data_operandB,
  output logic [DATA_WIDTH-1:0] data_result,
  output logic                  data_exception,
  output logic                  data_resultRDY
);

  state_t                state_q;
  logic [CNT_W-1:0]      count_q;
  logic [DATA_WIDTH-1:0] hi_q, lo_q, m_q, result_q;
  logic                  qm1_q, neg_q, div0_q, exc_q, rdy_q;

  logic [DATA_WIDTH-1:0] as_a, as_sum, div_shift, mult_hi, fin_res;
  logic                  as_sub, as_cout, as_ovf, booth_add, sign_in, fin_exc;

  addsub_32bit u_addsub (
    .a_i    (as_a),
    .b_i    (m_q),
    .cin_i  (1'b0),
    .sub_i  (as_sub),
    .sum_o  (as_sum),
    .cout_o (as_cout),
    .ovf_o  (as_ovf)
  );

  assign div_shift = {hi_q[DATA_WIDTH-2:0], lo_q[DATA_WIDTH-1]};
  assign booth_add = lo_q[0] ^ qm1_q;

  always_comb begin
    as_a   = hi_q;
    as_sub = lo_q[0] & ~qm1_q;
    if (state_q == ST_DIV) begin
      as_a   = div_shift;
      as_sub = 1'b1;
    end
  end

  // An add that overflows 32 bits still has a known true sign for the arithmetic shift.
  assign mult_hi = booth_add ? as_sum : hi_q;
  assign sign_in = booth_add ? (as_sum[DATA_WIDTH-1] ^ as_ovf) : hi_q[DATA_WIDTH-1];

  always_comb begin
    fin_res = lo_q;
    fin_exc = (hi_q != {DATA_WIDTH{lo_q[DATA_WIDTH-1]}});
    if (state_q == ST_DIV) begin
      if (div0_q) begin
        fin_res = '0;
        fin_exc = 1'b1;
      end else begin
        fin_res = neg_q ? negate(lo_q) : lo_q;
        fin_exc = ~neg_q & lo_q[DATA_WIDTH-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      qm1_q    <= 1'b0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else if (ctrl_MULT || ctrl_DIV) begin
      count_q <= '0;
      hi_q    <= '0;
      qm1_q   <= 1'b0;
      rdy_q   <= 1'b0;
      if (ctrl_MULT) begin
        state_q <= ST_MULT;
        lo_q    <= data_operandB;
        m_q     <= data_operandA;
        neg_q   <= 1'b0;
        div0_q  <= 1'b0;
      end else begin
        state_q <= ST_DIV;
        lo_q    <= magnitude(data_operandA);
        m_q     <= magnitude(data_operandB);
        neg_q   <= data_operandA[DATA_WIDTH-1] ^ data_operandB[DATA_WIDTH-1];
        div0_q  <= (data_operandB == '0);
      end
    end else begin
      case (state_q)
        ST_MULT, ST_DIV: begin
          if (count_q < CNT_W'(ITER_COUNT)) begin
            count_q <= count_q + 1'b1;
            if (state_q == ST_MULT) begin
              hi_q  <= {sign_in, mult_hi[DATA_WIDTH-1:1]};
              lo_q  <= {mult_hi[0], lo_q[DATA_WIDTH-1:1]};
              qm1_q <= lo_q[0];
            end else begin
              hi_q <= as_cout ? as_sum : div_shift;
              lo_q <= {lo_q[DATA_WIDTH-2:0], as_cout};
            end
          end else begin
            result_q <= fin_res;
            exc_q    <= fin_exc;
            rdy_q    <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          rdy_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          rdy_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench: directed vectors plus randomized operations against an arithmetic model.
module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  multdiv_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  // Reference: {exception, result} from full-width signed arithmetic.
  function automatic logic [32:0] model_mult(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return {(p[63:32] != {32{p[31]}}), p[31:0]};
  endfunction

  function automatic logic [32:0] model_div(input logic [31:0] a, input logic [31:0] b);
    longint q;
    if (b == 32'd0) return {1'b1, 32'd0};
    q = longint'($signed(a)) / longint'($signed(b));
    return {(q > 64'sd2147483647 || q < -64'sd2147483648), q[31:0]};
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40));
      4:       return 32'h0 - 32'($urandom_range(1, 40));
      5:       return 32'($urandom) & 32'h0000_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  // Drive a start pulse; returns one time unit after the sampling edge.
  task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT = m;
    ctrl_DIV = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
  endtask

  // Watch a fixed number of edges; latency of the first strobe is -1 if none arrives.
  task automatic watch(input int window, output int lat, output int strobes,
                       output logic [31:0] res, output logic exc);
    lat = -1;
    strobes = 0;
    res = '0;
    exc = 1'b0;
    for (int i = 1; i <= window; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        strobes++;
        if (lat < 0) begin
          lat = i;
          res = data_result;
          exc = data_exception;
        end
      end
    end
  endtask

  task automatic test_reset();
    int lat, n;
    logic [31:0] r;
    logic e;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    total++; if (data_result !== 32'd0) begin bad++; $display("FAIL reset_result: got %h want 00000000", data_result); end
    total++; if (data_exception !== 1'b0) begin bad++; $display("FAIL reset_exc: got %b want 0", data_exception); end
    total++; if (data_resultRDY !== 1'b0) begin bad++; $display("FAIL reset_rdy: got %b want 0", data_resultRDY); end
    // Reset outranks a simultaneous start.
    ctrl_MULT = 1'b1; data_operandA = 32'd9; data_operandB = 32'd9;
    @(posedge clock);
    #1;
    reset = 1'b0; ctrl_MULT = 1'b0;
    watch(40, lat, n, r, e);
    total++; if (n !== 0) begin bad++; $display("FAIL reset_priority_strobes: got %0d want 0", n); end
    // Start honoured on the first edge after reset deasserts.
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    start_op(1'b1, 1'b0, 32'd5, 32'd5);
    watch(40, lat, n, r, e);
    total++; if (lat !== 33 || r !== 32'd25) begin bad++; $display("FAIL reset_first_edge: got lat=%0d res=%h want lat=33 res=00000019", lat, r); end
    $display("test_reset: done");
  endtask

  task automatic test_spec_vectors();
    logic [31:0] va[5] = '{32'd7, 32'h0001_0000, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000};
    logic [31:0] vb[5] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic        vm[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] vr[5] = '{32'hFFFF_FFEB, 32'h0, 32'hFFFF_FFFD, 32'h0, 32'h8000_0000};
    logic        ve[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int lat, n;
    logic [31:0] r;
    logic e;
    for (int i = 0; i < 5; i++) begin
      start_op(vm[i], ~vm[i], va[i], vb[i]);
      watch(40, lat, n, r, e);
      total++;
      if (lat !== 33 || n !== 1 || r !== vr[i] || e !== ve[i]) begin
        bad++;
        $display("FAIL vector%0d: got lat=%0d strobes=%0d res=%h exc=%b want lat=33 strobes=1 res=%h exc=%b",
                 i, lat, n, r, e, vr[i], ve[i]);
      end
      $display("vector%0d %s A=%h B=%h -> res=%h exc=%b lat=%0d", i, vm[i] ? "MUL" : "DIV", va[i], vb[i], r, e, lat);
    end
  endtask

  task automatic test_random();
    int lat, n;
    logic [31:0] a, b, r;
    logic e, m;
    logic [32:0] exp;
    for (int i = 0; i < 30; i++) begin
      a = pick_operand();
      b = pick_operand();
      m = 1'($urandom_range(0, 1));
      exp = m ? model_mult(a, b) : model_div(a, b);
      start_op(m, ~m, a, b);
      watch(36, lat, n, r, e);
      total++;
      if (lat !== 33 || n !== 1 || r !== exp[31:0] || e !== exp[32]) begin
        bad++;
        $display("FAIL random%0d: %s A=%h B=%h got lat=%0d strobes=%0d res=%h exc=%b want res=%h exc=%b",
                 i, m ? "MUL" : "DIV", a, b, lat, n, r, e, exp[31:0], exp[32]);
      end
      $display("random%0d %s A=%h B=%h -> res=%h exc=%b", i, m ? "MUL" : "DIV", a, b, r, e);
    end
  endtask

  task automatic test_both_pulses();
    int lat, n;
    logic [31:0] r;
    logic e;
    logic [32:0] exp;
    exp = model_mult(32'hFFFF_FF00, 32'd300);
    start_op(1'b1, 1'b1, 32'hFFFF_FF00, 32'd300);
    watch(40, lat, n, r, e);
    total++;
    if (lat !== 33 || r !== exp[31:0] || e !== exp[32]) begin
      bad++;
      $display("FAIL both_pulses: got lat=%0d res=%h exc=%b want res=%h exc=%b", lat, r, e, exp[31:0], exp[32]);
    end
    $display("both_pulses -> res=%h exc=%b", r, e);
  endtask

  task automatic test_operand_change();
    int lat, n;
    logic [31:0] r;
    logic e;
    logic [32:0] exp;
    exp = model_div(32'd1000, 32'hFFFF_FFF9);
    start_op(1'b0, 1'b1, 32'd1000, 32'hFFFF_FFF9);
    data_operandA = 32'd3;
    data_operandB = 32'd1;
    repeat (10) @(posedge clock);
    #1;
    data_operandA = 32'h7FFF_0000;
    data_operandB = 32'd0;
    watch(30, lat, n, r, e);
    total++;
    if (lat !== 23 || n !== 1 || r !== exp[31:0] || e !== exp[32]) begin
      bad++;
      $display("FAIL operand_change: got lat=%0d res=%h exc=%b want lat=23 res=%h exc=%b", lat, r, e, exp[31:0], exp[32]);
    end
    $display("operand_change -> res=%h exc=%b", r, e);
  endtask

  task automatic test_back_to_back();
    int lat, n, wait_cnt;
    logic [31:0] r;
    logic e;
    logic [32:0] exp;
    start_op(1'b1, 1'b0, 32'h0000_1234, 32'hFFFF_0001);
    wait_cnt = 0;
    while (!data_resultRDY && wait_cnt < 40) begin
      @(posedge clock);
      #1;
      wait_cnt++;
    end
    exp = model_mult(32'h0000_1234, 32'hFFFF_0001);
    total++;
    if (wait_cnt !== 33 || data_result !== exp[31:0] || data_exception !== exp[32]) begin
      bad++;
      $display("FAIL b2b_first: got lat=%0d res=%h exc=%b want lat=33 res=%h exc=%b",
               wait_cnt, data_result, data_exception, exp[31:0], exp[32]);
    end
    // Next start is sampled on the edge leaving DONE.
    start_op(1'b0, 1'b1, 32'hFFFF_FC18, 32'd33);
    total++; if (data_resultRDY !== 1'b0) begin bad++; $display("FAIL b2b_strobe_width: got %b want 0", data_resultRDY); end
    exp = model_div(32'hFFFF_FC18, 32'd33);
    watch(40, lat, n, r, e);
    total++;
    if (lat !== 33 || n !== 1 || r !== exp[31:0] || e !== exp[32]) begin
      bad++;
      $display("FAIL b2b_second: got lat=%0d strobes=%0d res=%h exc=%b want res=%h exc=%b", lat, n, r, e, exp[31:0], exp[32]);
    end
    $display("back_to_back -> res=%h exc=%b", r, e);
  endtask

  task automatic test_abort();
    int lat, n, early;
    logic [31:0] r;
    logic e;
    start_op(1'b1, 1'b0, 32'd3, 32'd4);
    early = 0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) early++;
    end
    start_op(1'b0, 1'b1, 32'd100, 32'd10);
    watch(45, lat, n, r, e);
    total++;
    if (early !== 0 || n !== 1 || lat !== 33 || r !== 32'd10 || e !== 1'b0) begin
      bad++;
      $display("FAIL abort: got early=%0d strobes=%0d lat=%0d res=%h exc=%b want 0 1 33 0000000a 0", early, n, lat, r, e);
    end
    $display("abort -> strobes=%0d res=%h", n, r);
  endtask

  task automatic test_reset_mid();
    int lat, n;
    logic [31:0] r;
    logic e;
    start_op(1'b0, 1'b1, 32'd1000, 32'd7);
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    total++; if (data_result !== 32'd0) begin bad++; $display("FAIL midreset_result: got %h want 00000000", data_result); end
    total++; if (data_exception !== 1'b0) begin bad++; $display("FAIL midreset_exc: got %b want 0", data_exception); end
    watch(40, lat, n, r, e);
    total++; if (n !== 0) begin bad++; $display("FAIL midreset_strobes: got %0d want 0", n); end
    total++; if (data_result !== 32'd0) begin bad++; $display("FAIL midreset_hold: got %h want 00000000", data_result); end
    start_op(1'b1, 1'b0, 32'd6, 32'd7);
    watch(40, lat, n, r, e);
    total++;
    if (lat !== 33 || n !== 1 || r !== 32'd42 || e !== 1'b0) begin
      bad++;
      $display("FAIL midreset_recover: got lat=%0d res=%h exc=%b want lat=33 res=0000002a exc=0", lat, r, e);
    end
    $display("reset_mid -> res=%h", r);
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_random();
    test_both_pulses();
    test_operand_change();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multdiv_sequencer.md
MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 The block SHALL have the port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port: reset  input  1  synchronous, active-high reset.
REQ-003 The block SHALL have the port: ctrl_MULT  input  1  single-cycle pulse that starts a signed multiply.
REQ-004 The block SHALL have the port: ctrl_DIV  input  1  single-cycle pulse that starts a signed divide.
REQ-005 The block SHALL have the port: data_operandA  input  32  multiplicand or dividend, sampled only on a start cycle.
REQ-006 The block SHALL have the port: data_operandB  input  32  multiplier or divisor, sampled only on a start cycle.
REQ-007 The block SHALL have the port: data_result  output  32  low product word or quotient.
REQ-008 The block SHALL have the port: data_exception  output  1  overflow or divide-by-zero flag, valid with data_resultRDY.
REQ-009 The block SHALL have the port: data_resultRDY  output  1  one-cycle completion strobe.

Function
REQ-010 The block SHALL implement the states IDLE, MULT, DIV and DONE.
REQ-011 In IDLE, MULT, DIV or DONE, a start pulse SHALL latch both operands and clear the iteration counter; ctrl_MULT moves the block to MULT and ctrl_DIV moves it to DIV.
REQ-012 When ctrl_MULT and ctrl_DIV are asserted in the same cycle, the block SHALL start a multiply and SHALL ignore ctrl_DIV.
REQ-013 A start pulse that arrives during MULT or DIV SHALL abort the current operation and restart with the new operands; the aborted operation SHALL NOT produce a data_resultRDY strobe.
REQ-014 The block SHALL perform exactly 32 iterations, one per clock; after the 32nd iteration it SHALL enter DONE.
REQ-015 data_resultRDY SHALL be high for exactly one cycle, the cycle in DONE, which is 33 rising edges after the start-sampling edge; the next edge SHALL return the block to IDLE.
REQ-016 data_result and data_exception SHALL hold their last values from DONE until the next DONE.
REQ-017 Multiply SHALL use radix-2 Booth recoding on a 65-bit {A, Q, q-1} register, using one shared 32-bit add/sub per iteration followed by an arithmetic right shift.
REQ-018 The multiply result SHALL be bits [31:0] of the 64-bit signed product.
REQ-019 The multiply exception SHALL be 1 when bits [63:32] of the product are not all equal to bit 31.
REQ-020 Divide SHALL be signed, non-restoring or restoring, and operate on operand magnitudes; the quotient SHALL be negated when the operand signs differ, and the quotient SHALL truncate toward zero.
REQ-021 The remainder SHALL be discarded.
REQ-022 When the divisor is 0, data_result SHALL be 0x00000000 and data_exception SHALL be 1, with the same 33-cycle latency.
REQ-023 For 0x80000000 / 0xFFFFFFFF, data_result SHALL be 0x80000000 and data_exception SHALL be 1.
REQ-024 Subtraction SHALL be formed as the bitwise inverse of the operand plus a carry-in of 1, and negation SHALL be formed the same way.
REQ-025 A change on an operand outside a start cycle SHALL have no effect on the operation in progress.

Reset
REQ-026 When reset is high at a rising edge, the block SHALL go to IDLE, clear the counter and all datapath registers, and drive data_result=0, data_exception=0 and data_resultRDY=0.
REQ-027 Reset asserted in the middle of an operation SHALL abort that operation with no strobe.
REQ-028 Reset SHALL take priority over a start pulse in the same cycle.
REQ-029 Start pulses SHALL be honoured from the first edge after reset deasserts.

Structure
REQ-030 The shared package multdiv_pkg SHALL define the state encoding, DATA_WIDTH=32 and ITER_COUNT=32.
REQ-031 A single sub-module, addsub_32bit (a 32-bit adder with carry-in and a subtract select), SHALL be instantiated once and shared by the multiply and divide paths.
REQ-032 The sequencer SHALL contain only the FSM, the counter, the operand/product registers and the sign-fixup logic.

Verification
REQ-033 The bench SHALL pulse ctrl_MULT with A=7, B=-3 and check that data_resultRDY rises exactly 33 edges later with data_result=0xFFFFFFEB and data_exception=0.
REQ-034 The bench SHALL pulse ctrl_MULT with A=0x00010000, B=0x00010000 and check data_result=0x00000000 and data_exception=1.
REQ-035 The bench SHALL pulse ctrl_DIV with A=-7, B=2 and check data_result=0xFFFFFFFD and data_exception=0; it SHALL then pulse ctrl_DIV with A=5, B=0 and check data_result=0 and data_exception=1.
REQ-036 The bench SHALL pulse ctrl_DIV with A=0x80000000, B=0xFFFFFFFF and check data_result=0x80000000 and data_exception=1.
REQ-037 The bench SHALL start a multiply of 3x4, pulse ctrl_DIV with 100/10 ten cycles later, and check for a single strobe 33 edges after the second pulse carrying data_result=10.
REQ-038 The bench SHALL assert reset at iteration 15 of a divide, then check for no strobe and all outputs 0, and then check that a fresh ctrl_MULT with 6x7 yields 42.
